// File: rtl/rst_release_seq_if.sv
// Software reset handshake and domain reset outputs of the reset release sequencer.
interface rst_release_seq_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   SWREQ;
  logic                   SWACK;
  logic [NUM_DOMAINS-1:0] RN;
  logic                   READY;
  logic [2:0]             STATE;

  modport master (output SWREQ, input SWACK, input RN, input READY, input STATE);
  modport slave  (input SWREQ, output SWACK, output RN, output READY, output STATE);
endinterface

// File: rtl/rst_release_seq.sv
// Asserts domain resets asynchronously; releases them synchronously after a hold
// period, one domain every STAGGER cycles, with a software re-entry handshake.
module rst_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 3,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 5
) (
  input  logic             CLK,
  input  logic             R,
  rst_release_seq_if.slave bus
);

  localparam int REL_SPAN  = STAGGER * (NUM_DOMAINS - 1);
  localparam int CNT_NEED  = (HOLD_CYCLES > REL_SPAN) ? HOLD_CYCLES : REL_SPAN;
  localparam int REL_LAST_I = (NUM_DOMAINS > 1) ? REL_SPAN - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_LAST_I);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_release_seq: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_release_seq: HOLD_CYCLES must be >= 1");
  end
  if (NUM_DOMAINS < 1) begin : g_bad_dom
    $error("rst_release_seq: NUM_DOMAINS must be >= 1");
  end
  if (STAGGER < 1) begin : g_bad_stag
    $error("rst_release_seq: STAGGER must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 30 || CNT_NEED > (1 << CNT_W) - 1) begin : g_bad_cnt
    $error("rst_release_seq: CNT_W too narrow for HOLD_CYCLES / stagger span");
  end

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SWRST   = 3'd4
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_DOMAINS-1:0] rn;
  logic [NUM_DOMAINS-1:0] rel_mask;
  logic                   ready;
  logic                   swack;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_out;

  // Release synchroniser: D of the first flop is tied high
  always_ff @(posedge CLK or posedge R) begin
    if (R) sync_chain <= '0;
    else   sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out = sync_chain[SYNC_STAGES-1];

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_rel
    if (k == 0) begin : g_first
      assign rel_mask[k] = 1'b0;
    end else begin : g_next
      assign rel_mask[k] = (cnt == CNT_W'(STAGGER * k - 1));
    end
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state <= ST_ASSERT;
      cnt   <= '0;
      rn    <= '0;
      ready <= 1'b0;
      swack <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (sync_out) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            rn[0] <= 1'b1;
            if (NUM_DOMAINS == 1) begin
              ready <= 1'b1;
              state <= ST_RUN;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          rn <= rn | rel_mask;
          if (cnt == REL_LAST) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= ST_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.SWREQ) begin
            rn    <= '0;
            ready <= 1'b0;
            swack <= 1'b1;
            state <= ST_SWRST;
          end
        end
        ST_SWRST: begin
          // Leaving SWRST restarts the full hold and stagger sequence
          if (!bus.SWREQ) begin
            swack <= 1'b0;
            cnt   <= '0;
            state <= ST_HOLD;
          end
        end
        default: begin
          state <= ST_ASSERT;
          cnt   <= '0;
          rn    <= '0;
          ready <= 1'b0;
          swack <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RN    = rn;
  assign bus.READY = ready;
  assign bus.SWACK = swack;
  assign bus.STATE = state;

endmodule

// File: tb/tb_rst_release_seq.sv
// Scoreboard bench: an edge-count model of the release schedule predicts outputs
// per cycle; a negedge monitor compares two DUT configurations against it.
module tb_rst_release_seq;

  localparam int SS = 2;
  localparam int HC = 16;
  localparam int ND = 3;
  localparam int ST = 4;

  typedef struct packed {
    logic [ND-1:0] rn;
    logic          ready;
    logic          swack;
    logic [2:0]    state;
    logic          rn2;
    logic          ready2;
    logic [2:0]    state2;
  } exp_t;

  logic CLK = 1'b0;
  logic R;

  rst_release_seq_if #(.NUM_DOMAINS(ND)) bus ();
  rst_release_seq_if #(.NUM_DOMAINS(1))  bus2 ();

  rst_release_seq #(.SYNC_STAGES(SS), .HOLD_CYCLES(HC), .NUM_DOMAINS(ND), .STAGGER(ST), .CNT_W(5))
    dut (.CLK(CLK), .R(R), .bus(bus.slave));

  rst_release_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_DOMAINS(1), .STAGGER(4), .CNT_W(5))
    dut1 (.CLK(CLK), .R(R), .bus(bus2.slave));

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  bit   started  = 0;
  bit   done     = 0;

  // Reference model: edges counted since R fell, plus the edge HOLD was entered
  bit in_rst     = 1;
  bit swrst_mode = 0;
  bit sw_cur     = 0;
  int edge_n     = 0;
  int hold_start = SS + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    int r0, rdy;
    e = '0;
    if (in_rst) return e;
    r0  = hold_start + HC;
    rdy = r0 + ST * (ND - 1);
    if (swrst_mode) begin
      e.swack = 1'b1;
      e.state = 3'd4;
    end else begin
      e.state = (edge_n < hold_start) ? 3'd0 : (edge_n < r0) ? 3'd1 : (edge_n < rdy) ? 3'd2 : 3'd3;
      for (int k = 0; k < ND; k++) e.rn[k] = (edge_n >= r0 + ST * k);
      e.ready = (edge_n >= rdy);
    end
    e.state2 = (edge_n < SS + 1) ? 3'd0 : (edge_n < SS + 2) ? 3'd1 : 3'd3;
    e.rn2    = (edge_n >= SS + 2);
    e.ready2 = (edge_n >= SS + 2);
    return e;
  endfunction

  task automatic model_edge();
    bit in_run;
    if (in_rst) return;
    in_run = !swrst_mode && (edge_n >= hold_start + HC + ST * (ND - 1));
    if (in_run && sw_cur) swrst_mode = 1;
    else if (swrst_mode && !sw_cur) begin
      swrst_mode = 0;
      hold_start = edge_n + 1;
    end
    edge_n++;
  endtask

  task automatic model_release();
    in_rst     = 0;
    swrst_mode = 0;
    edge_n     = 0;
    hold_start = SS + 1;
  endtask

  // pulse: 0 none, 1 = 1 ns R pulse between edges, 2 = R asserted mid-cycle and left high
  task automatic step(input bit sw, input bit rl, input int pulse);
    @(posedge CLK);
    model_edge();
    #1;
    bus.SWREQ = sw;
    sw_cur    = sw;
    R         = rl;
    if (rl && !in_rst) in_rst = 1;
    else if (!rl && in_rst) model_release();
    if (pulse != 0) begin
      #1;
      R      = 1'b1;
      in_rst = 1;
      #1;
      check("async_rn",    32'(bus.RN),    32'd0);
      check("async_ready", 32'(bus.READY), 32'd0);
      check("async_swack", 32'(bus.SWACK), 32'd0);
      check("async_state", 32'(bus.STATE), 32'd0);
      check("async_rn_1d", 32'(bus2.RN),   32'd0);
      if (pulse == 1) begin
        R = 1'b0;
        model_release();
      end
    end
    sb.push_back(expect_now());
    started = 1;
  endtask

  task automatic steps(input int n, input bit sw);
    for (int i = 0; i < n; i++) step(sw, 1'b0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (started && !done) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rn",     32'(bus.RN),     32'(e.rn));
          check("ready",  32'(bus.READY),  32'(e.ready));
          check("swack",  32'(bus.SWACK),  32'(e.swack));
          check("state",  32'(bus.STATE),  32'(e.state));
          check("rn_1d",    32'(bus2.RN),    32'(e.rn2));
          check("ready_1d", 32'(bus2.READY), 32'(e.ready2));
          check("state_1d", 32'(bus2.STATE), 32'(e.state2));
          check("swack_1d", 32'(bus2.SWACK), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int r_hold;
    int x;
    bit sw;
    R          = 1'b1;
    bus.SWREQ  = 1'b0;
    bus2.SWREQ = 1'b0;

    // power-on: R high for 3 cycles, then full release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    steps(23, 1'b0);
    // reset while in RELEASE with RN=011, held across two edges
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    steps(32, 1'b0);
    // software reset from RUN, 5 cycles of SWREQ
    steps(5, 1'b1);
    steps(30, 1'b0);
    // SWREQ held through HOLD and RELEASE, then sampled on RUN entry
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    steps(30, 1'b1);
    steps(30, 1'b0);
    // 1 ns R pulse while in RUN
    step(1'b0, 1'b0, 1);
    steps(32, 1'b0);

    // randomized SWREQ bursts and occasional resets
    r_hold = 0;
    sw     = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 5) == 0) sw = ~sw;
      x = int'($urandom_range(0, 149));
      if (r_hold > 0) begin
        step(sw, 1'b1, 0);
        r_hold--;
      end else if (x == 0) begin
        step(sw, 1'b0, 1);
      end else if (x == 1) begin
        step(sw, 1'b0, 2);
        r_hold = int'($urandom_range(0, 3));
      end else begin
        step(sw, 1'b0, 0);
      end
    end
    steps(40, 1'b0);

    @(negedge CLK);
    #1;
    done = 1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_release_seq.md
Name: rst_release_seq

Overview:
Generates the active-low reset inputs (RN) for downstream asynchronous-reset flip-flop cells and cell-based test structures. Reset assertion is immediate and asynchronous. Release is synchronised to CLK, held off for a programmable number of cycles, and staggered across domains, so every receiving flop meets its RN recovery/removal and minimum RN-low-width checks. A software reset request/acknowledge handshake re-enters reset synchronously.

Parameters:
SYNC_STAGES, 2, depth of the R-release synchroniser chain; must be >= 2
HOLD_CYCLES, 16, CLK cycles RN is held low after the synchroniser output goes high; must be >= 1
NUM_DOMAINS, 3, number of RN outputs; must be >= 1
STAGGER, 4, CLK cycles between successive RN releases; must be >= 1
CNT_W, 5, counter width; must hold max(HOLD_CYCLES, STAGGER*(NUM_DOMAINS-1))

Ports:
CLK  input  1  clock, rising-edge
R  input  1  reset; asynchronous, active-high
SWREQ  input  1  software reset request, synchronous to CLK
SWACK  output  1  software reset acknowledge
RN  output  NUM_DOMAINS  active-low domain resets; bit 0 is released first
READY  output  1  high when all RN bits are released
STATE  output  3  FSM state, for debug

Behaviour:
- Interface (already decided): one clock, CLK. Reset R is asynchronous and active-high.
- All outputs are registered. There is no combinational path from R, SWREQ or CLK to any output except the asynchronous clear.
- R high (at any time, in any state):
  - RN = all 0, READY = 0, SWACK = 0, STATE = ASSERT(0), synchroniser chain = 0, counter = 0.
  - All of these take effect immediately, without waiting for a clock edge.
- Synchroniser: a chain of SYNC_STAGES flops; the first flop's D input is tied to 1. The chain output goes high at rising edge SYNC_STAGES after R falls (edge 1 is the first rising edge after R low).
- FSM states: ASSERT=0, HOLD=1, RELEASE=2, RUN=3, SWRST=4.
  - ASSERT: when the chain output is 1 -> HOLD, counter cleared. With defaults this is edge 3.
  - HOLD: RN all 0. Counter increments each edge. At the edge where counter == HOLD_CYCLES-1 -> RELEASE, counter cleared, RN[0] set to 1 on that same edge.
  - RELEASE: counter increments each edge. RN[k] is set to 1 at the edge where the counter reaches STAGGER*k-1 (k >= 1), so bits release STAGGER cycles apart. On the edge that releases RN[NUM_DOMAINS-1], READY is set to 1 and the FSM moves -> RUN. If NUM_DOMAINS = 1, READY and RUN occur on the same edge as RN[0].
  - RUN: RN all 1, READY = 1. SWREQ = 1 sampled at an edge -> SWRST: RN all 0, READY 0, SWACK 1, all on that edge.
  - SWRST: SWACK stays 1 while SWREQ = 1. SWREQ = 0 sampled -> SWACK 0, counter cleared, -> HOLD. Full hold and stagger sequence then repeats.
- SWREQ is ignored in ASSERT, HOLD and RELEASE; SWACK stays 0 in those states.
- Cycle timing with defaults: RN[0] rises at edge 19 after R falls, RN[1] at edge 23, RN[2] at edge 27, READY at edge 27.
- Once set, RN bits never fall except on R or entry to SWRST. No glitches, and no partial release order violations.
- R asserted mid-HOLD, mid-RELEASE or in SWRST: immediate return to ASSERT, and the full sequence restarts on release.
- R pulse shorter than one CLK period still clears everything. The release count starts from the synchroniser chain only.
- Counter never wraps. Parameter legality is checked at elaboration, and an out-of-range value is an error.

Test Plan:
- Power-on, defaults: R high for 3 cycles, then low -> RN=000 and READY=0 through edge 18; RN=001 at edge 19, 011 at 23, 111 at 27; READY=1 at 27; STATE=3.
- R asserted asynchronously mid-clock while in RELEASE (RN=011) -> RN=000, READY=0, STATE=0 before the next CLK edge; the release sequence then repeats with identical edge counts.
- In RUN, SWREQ high for 5 cycles -> RN=000, SWACK=1 on the first sampling edge. SWREQ low -> SWACK=0 on the next edge; RN[0] rises 16 edges later, RN[2] and READY 8 edges after that.
- SWREQ held high during HOLD and RELEASE -> SWACK remains 0 and the sequence is unaffected. On RUN entry, SWREQ is sampled at the next edge and RN returns to 000.
- NUM_DOMAINS=1, HOLD_CYCLES=1, SYNC_STAGES=2 -> RN[0] and READY rise together at edge 4 after R falls.
- R pulse of 1 ns with no CLK edge during it, asserted in RUN -> RN clears immediately; the full sequence resumes with RN[0] at edge 19.
